i2s_core: RTL and testbench
===========================

# i2s_core

Audio codec serial-port bridge. It derives the I2S master clocks (mclk, sclk, lrck) from the 100 MHz system clock and converts between the codec's serial lines (sdi in, sdo out) and two 24-bit valid/ready sample streams. Received ADC samples leave on the rx stream; DAC samples enter on the tx stream. The block sits between the codec pins and the effects pipeline.

## Interface
- DATA_WIDTH, 24: sample width in bits. Only 24 is required to be supported.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- rx_data  out  DATA_WIDTH  received sample.
- rx_vld  out  1  rx_data holds an unconsumed sample.
- rx_rdy  in  1  downstream accepts; transfer when rx_vld & rx_rdy.
- tx_data  in  DATA_WIDTH  sample to transmit.
- tx_vld  in  1  tx_data valid.
- tx_rdy  out  1  holding buffer empty; transfer when tx_vld & tx_rdy.
- mclk  out  1  codec master clock, clk/4 (25 MHz).
- sclk  out  1  serial bit clock, clk/32 (3.125 MHz).
- lrck  out  1  word select, clk/2048 (~48.83 kHz); 0 = left, 1 = right.
- sdi  in  1  serial data from ADC.
- sdo  out  1  serial data to DAC.

## Operation
- Free-running 11-bit counter c increments every clk and wraps 2047→0.
- Clock outputs: mclk = c[1], sclk = c[4], lrck = c[10]. These are all registered-counter bits and glitch-free.
- Each channel half occupies c[9:0] = 0..1023. Slot s = c[9:5] (0..31), one sclk period per slot.
- The format is standard I2S, MSB first. The MSB sits in slot 1, one sclk after the lrck edge. Slots 1..24 carry bits 23..0. Slots 0 and 25..31 are padding.
- Sample order on both streams is L, R, L, R. The first rx sample after reset is left.

Receive path:
- Sample sdi on the clk edge where c[4:0]==15, which is the sclk rising edge, for slots 1..24. Shift the bit into a 24-bit register, MSB first.
- At the slot-24 sample edge (c[9:0]==783), load rx_data with the complete word and set rx_vld.
- An rx transfer clears rx_vld.
- If a new word completes while rx_vld is still 1, it overwrites rx_data and rx_vld stays 1. The older sample is dropped.

Transmit path:
- A one-entry holding buffer loads on a tx handshake. tx_rdy = buffer empty.
- At the edge where c[9:0]==1023 (end of each channel half):
  - The buffer moves into the tx shift register and the buffer empties.
  - If the buffer is empty at that edge (underrun), the shift register loads 0.
  - sdo is driven to 0 for slot 0.
- At each edge where c[4:0]==31 in slots 0..23, sdo takes shift[23] and the register shifts left. This is the sclk falling edge, so sdo changes on falling edges only.
- At the same edge in slots 24..30, sdo is driven to 0.
- A buffer load and the transfer to the shift register can happen on the same edge. The shift register takes the old buffer contents and the buffer holds the new word (full).

## Timing
- Reset values: c=0, so mclk=sclk=lrck=0. Also sdo=0, rx_vld=0, rx_data=0, buffer empty (tx_rdy=1), shift registers 0.
- Rx latency: rx_vld is high on the cycle after the LSB sample edge, i.e. c=784 for left and c=1808 for right.
- Tx latency: the MSB of a word accepted before c[9:0]==1023 appears on sdo from c[9:0]=32 of the next half. It stays for 32 clk per bit.
- Reset mid-frame: everything returns to the reset values immediately. The partial rx word is discarded and the buffered tx word is lost.
- Handshakes follow the AXI-Stream style:
  - rx_data and rx_vld must not change while rx_vld=1 and rx_rdy=0, except on overwrite at c[9:0]==783.
  - tx_rdy does not depend combinationally on tx_vld.

## Test plan
- Reset: hold rst=0 for 20 clk, then check all outputs are at their reset values. After release, check the mclk period is 40 ns, the sclk period is 320 ns and the lrck period is 20.48 µs. The first lrck rise is 10.24 µs after release.
- Rx pattern: sdi toggles on each sclk falling edge, starting at 0; rx_rdy=1. Expect every rx sample = 0xAAAAAA, rx_vld pulses once per channel, at c=784 and c=1808.
- Tx pattern: tx_vld=1, supply 0xA5A5A5 then 0x123456. Decode sdo on sclk rising edges: left slots 1..24 carry 0xA5A5A5, right slots 1..24 carry 0x123456, and padding slots are 0.
- Tx underrun: hold tx_vld=0. sdo stays 0 for the whole frame and tx_rdy stays 1.
- Rx backpressure: hold rx_rdy=0 over two channel halves. rx_vld stays 1 and rx_data is replaced by the right-channel word at c=1808. Raising rx_rdy for one cycle clears rx_vld.
- Random tx stream: tx_vld=1, data changes on every handshake. Check that each sample transmitted on sdo matches the accepted sequence in order, with no duplicates or skips.

Source files
------------

// File: rtl/i2s_core.sv
// I2S master bridge: derives mclk/sclk/lrck from a free-running counter and
// converts between the codec serial lines and two valid/ready sample streams.
module i2s_core #(
    parameter int unsigned DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_vld,
    input  logic                  rx_rdy,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_vld,
    output logic                  tx_rdy,
    output logic                  mclk,
    output logic                  sclk,
    output logic                  lrck,
    input  logic                  sdi,
    output logic                  sdo
);

    // Last data slot of a channel half; slot 0 is the I2S one-bit delay.
    localparam logic [4:0] LastSlot = 5'(DATA_WIDTH);

    logic [10:0]           cnt_q;
    logic [4:0]            slot;
    logic [4:0]            phase;
    logic                  rx_sample;
    logic                  rx_done;
    logic                  half_end;
    logic                  tx_shift_en;
    logic                  tx_pad;
    logic                  tx_load;

    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_vld_q, rx_vld_d;
    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic                  tx_full_q, tx_full_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  sdo_q, sdo_d;

    assign slot  = cnt_q[9:5];
    assign phase = cnt_q[4:0];

    // phase 15 is the edge on which sclk rises; phase 31 the edge on which it falls.
    assign rx_sample   = (phase == 5'd15) && (slot != 5'd0) && (slot <= LastSlot);
    assign rx_done     = rx_sample && (slot == LastSlot);
    assign half_end    = (cnt_q[9:0] == 10'd1023);
    assign tx_shift_en = (phase == 5'd31) && (slot < LastSlot);
    assign tx_pad      = (phase == 5'd31) && (slot >= LastSlot) && (slot != 5'd31);
    assign tx_load     = tx_vld && !tx_full_q;

    assign mclk    = cnt_q[1];
    assign sclk    = cnt_q[4];
    assign lrck    = cnt_q[10];
    assign rx_data = rx_data_q;
    assign rx_vld  = rx_vld_q;
    assign tx_rdy  = !tx_full_q;
    assign sdo     = sdo_q;

    // Free-running clock divider; all codec clocks are taps of this register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 11'd1;
        end
    end

    // Receive: shift sdi MSB first; publish the word on the last sample edge.
    always_comb begin
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_vld_d   = rx_vld_q;
        if (rx_sample) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], sdi};
        end
        if (rx_vld_q && rx_rdy) begin
            rx_vld_d = 1'b0;
        end
        // A fresh word wins over both a pending and a just-accepted one.
        if (rx_done) begin
            rx_data_d = {rx_shift_q[DATA_WIDTH-2:0], sdi};
            rx_vld_d  = 1'b1;
        end
    end

    // Transmit: one-entry buffer feeding a shift register reloaded every half.
    always_comb begin
        tx_buf_d   = tx_buf_q;
        tx_full_d  = tx_full_q;
        tx_shift_d = tx_shift_q;
        sdo_d      = sdo_q;
        if (tx_load) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end
        if (half_end) begin
            // Underrun sends silence rather than repeating the last word.
            tx_shift_d = tx_full_q ? tx_buf_q : '0;
            if (!tx_load) begin
                tx_full_d = 1'b0;
            end
            sdo_d = 1'b0;
        end else if (tx_shift_en) begin
            sdo_d      = tx_shift_q[DATA_WIDTH-1];
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
        end else if (tx_pad) begin
            sdo_d = 1'b0;
        end
    end

    // Datapath state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_vld_q   <= 1'b0;
            tx_buf_q   <= '0;
            tx_full_q  <= 1'b0;
            tx_shift_q <= '0;
            sdo_q      <= 1'b0;
        end else begin
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_vld_q   <= rx_vld_d;
            tx_buf_q   <= tx_buf_d;
            tx_full_q  <= tx_full_d;
            tx_shift_q <= tx_shift_d;
            sdo_q      <= sdo_d;
        end
    end

endmodule

// File: tb/tb_i2s_core.sv
// Scoreboard bench for i2s_core: drivers push expected samples into queues,
// monitors pop and compare when the DUT presents data.
`timescale 1ns/1ps
module tb_i2s_core;

    localparam int ClkPeriod = 10;

    logic        clk;
    logic        rst;
    logic [23:0] rx_data;
    logic        rx_vld;
    logic        rx_rdy;
    logic [23:0] tx_data;
    logic        tx_vld;
    logic        tx_rdy;
    logic        mclk;
    logic        sclk;
    logic        lrck;
    logic        sdi;
    logic        sdo;

    i2s_core #(.DATA_WIDTH(24)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_vld  (rx_vld),
        .rx_rdy  (rx_rdy),
        .tx_data (tx_data),
        .tx_vld  (tx_vld),
        .tx_rdy  (tx_rdy),
        .mclk    (mclk),
        .sclk    (sclk),
        .lrck    (lrck),
        .sdi     (sdi),
        .sdo     (sdo)
    );

    initial begin
        clk = 1'b0;
        forever #(ClkPeriod / 2) clk = ~clk;
    end

    typedef struct {
        logic [23:0] data;
        int unsigned at;
    } acc_t;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [23:0] rx_exp[$];
    acc_t        tx_acc[$];
    logic [23:0] tx_src[$];

    int          rx_mode = 0;      // 0 idle, 1 toggle pattern, 2 directed words
    logic [23:0] rx_word_l = '0;
    logic [23:0] rx_word_r = '0;
    bit          tx_en = 1'b0;

    // Bench's own model of the frame counter.
    int unsigned tc;
    always @(posedge clk or negedge rst) begin
        if (!rst) tc <= 0;
        else      tc <= tc + 1;
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    endfunction

    // Clock period measurement.
    time mclk_t = 0, mclk_per = 0, sclk_t = 0, sclk_per = 0, lrck_t = 0, lrck_per = 0;
    time lrck_first = 0, t_rel = 0;
    always @(posedge mclk) begin mclk_per = $time - mclk_t; mclk_t = $time; end
    always @(posedge sclk) begin sclk_per = $time - sclk_t; sclk_t = $time; end
    always @(posedge lrck) begin
        lrck_per = $time - lrck_t;
        lrck_t   = $time;
        if (lrck_first == 0) lrck_first = $time;
    end

    // Drivers: update inputs just after each rising edge.
    logic [4:0]  d_slot;
    logic [23:0] d_word;
    acc_t        d_acc;
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            sdi    = 1'b0;
            tx_vld = 1'b0;
        end else begin
            d_slot = tc[9:5];
            d_word = tc[10] ? rx_word_r : rx_word_l;
            case (rx_mode)
                1:       sdi = tc[5];
                2:       sdi = (d_slot >= 5'd1 && d_slot <= 5'd24) ? d_word[24 - d_slot] : 1'b0;
                default: sdi = 1'b0;
            endcase
            if (rx_mode != 0 && tc[9:0] == 10'd32) begin
                // An unconsumed older word will be overwritten by this one.
                if (rx_exp.size() > 0) void'(rx_exp.pop_back());
                rx_exp.push_back(rx_mode == 1 ? 24'hAAAAAA : d_word);
            end
            tx_vld  = tx_en && (tx_src.size() > 0);
            tx_data = tx_vld ? tx_src[0] : 24'h0;
            if (tx_vld && tx_rdy) begin
                d_acc.data = tx_src[0];
                d_acc.at   = tc;
                tx_acc.push_back(d_acc);
                void'(tx_src.pop_front());
            end
        end
    end

    // Monitors: sample on the falling clk edge.
    logic [9:0]  m_p;
    logic [4:0]  m_slot;
    logic [23:0] got;
    logic [23:0] exp_word;
    logic        pad, unstable, sdo_prev, vld_prev;
    logic [31:0] rx_want;
    acc_t        m_acc;
    always @(negedge clk) begin
        if (!rst) begin
            got = '0; pad = 1'b0; unstable = 1'b0; sdo_prev = 1'b0;
            exp_word = '0; vld_prev = 1'b0;
        end else begin
            m_p    = tc[9:0];
            m_slot = m_p[9:5];
            if (rx_vld && !vld_prev) check("rx_vld_rise_phase", 32'(m_p), 32'd784);
            vld_prev = rx_vld;
            if (rx_vld && rx_rdy) begin
                rx_want = (rx_exp.size() > 0) ? 32'(rx_exp.pop_front()) : 32'hDEADBEEF;
                check("rx_data", 32'(rx_data), rx_want);
            end
            if (m_p[4:0] == 5'd16) begin
                if (m_slot >= 5'd1 && m_slot <= 5'd24) got = {got[22:0], sdo};
                else pad = pad | sdo;
            end
            if (m_p[4:0] != 5'd0 && sdo !== sdo_prev) unstable = 1'b1;
            sdo_prev = sdo;
            if (m_p == 10'd1023) begin
                check("tx_word", 32'(got), 32'(exp_word));
                check("tx_pad", 32'(pad), 32'd0);
                check("sdo_fall_only", 32'(unstable), 32'd0);
                got = '0; pad = 1'b0; unstable = 1'b0;
                // Next half carries a word accepted on an earlier edge, else silence.
                if (tx_acc.size() > 0 && tx_acc[0].at < tc) begin
                    m_acc    = tx_acc.pop_front();
                    exp_word = m_acc.data;
                end else begin
                    exp_word = '0;
                end
            end
        end
    end

    task automatic goto(input int unsigned t);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (tc != t && guard < 20000);
        if (tc != t) begin
            $display("FAIL goto: actual tc %0d required %0d", tc, t);
            $fatal(1);
        end
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst = 1'b0;
        rx_exp.delete();
        tx_acc.delete();
        tx_src.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mclk"},    32'(mclk),    32'd0);
        check({tag, "_sclk"},    32'(sclk),    32'd0);
        check({tag, "_lrck"},    32'(lrck),    32'd0);
        check({tag, "_sdo"},     32'(sdo),     32'd0);
        check({tag, "_rx_vld"},  32'(rx_vld),  32'd0);
        check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        check({tag, "_tx_rdy"},  32'(tx_rdy),  32'd1);
    endtask

    logic rdy_low;
    initial begin
        rst = 1'b0; rx_rdy = 1'b1; sdi = 1'b0; tx_vld = 1'b0; tx_data = '0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");

        // Toggle pattern on rx; A5A5A5 left then 123456 right on tx; then underrun.
        rx_mode = 1;
        t_rel   = $time;
        rst     = 1'b1;
        goto(1100);
        tx_src.push_back(24'hA5A5A5);
        tx_src.push_back(24'h123456);
        tx_en = 1'b1;
        goto(4100);
        check("mclk_period", 32'(mclk_per), 32'd40);
        check("sclk_period", 32'(sclk_per), 32'd320);
        check("lrck_period", 32'(lrck_per), 32'd20480);
        // Release lands half a clk before the first counting edge.
        check("lrck_first_rise", 32'(lrck_first - t_rel), 32'(1024 * ClkPeriod - ClkPeriod / 2));
        rdy_low = 1'b0;
        repeat (2040) begin
            @(negedge clk);
            if (!tx_rdy) rdy_low = 1'b1;
        end
        check("tx_rdy_underrun", 32'(rdy_low), 32'd0);

        // Backpressure: left word held, then overwritten by right at 1808.
        enter_reset();
        tx_en = 1'b0; rx_mode = 2; rx_rdy = 1'b0;
        rx_word_l = 24'h5A0F3C; rx_word_r = 24'h0F1E2D;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        goto(1500);
        check("bp_vld_held", 32'(rx_vld), 32'd1);
        check("bp_data_left", 32'(rx_data), 32'h5A0F3C);
        goto(1808);
        check("bp_vld_overwrite", 32'(rx_vld), 32'd1);
        check("bp_data_right", 32'(rx_data), 32'h0F1E2D);
        goto(1899);
        @(posedge clk); #1 rx_rdy = 1'b1;
        @(posedge clk); #1 rx_rdy = 1'b0;
        @(negedge clk);
        check("bp_vld_cleared", 32'(rx_vld), 32'd0);

        // Random tx stream, then a reset in the middle of a half.
        enter_reset();
        rx_mode = 1; rx_rdy = 1'b1; tx_en = 1'b1;
        for (int i = 0; i < 6; i++) tx_src.push_back(24'($urandom));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        goto(8300);
        tx_src.push_back(24'hC0FFEE);
        goto(8499);
        check("mid_buf_full", 32'(tx_rdy), 32'd0);
        enter_reset();
        #1;
        check_reset_vals("mid_reset");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        goto(2100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
